sort_net_pipe: RTL

SORT_NET_PIPE -- requirements
Module: sort_net_pipe

---
 rtl/sort_net_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/sort_net_pipe.sv
// sort_net_pipe: pipelined bitonic sorting network.
// Each stage is one column of N/2 unsigned compare-exchange cells followed by
// a register bank holding data, valid and the per-vector order bit, so
// vectors of either order can share the pipeline.
// A single global advance enable stalls every stage at once under output
// backpressure.

module sort_net_pipe #(
  parameter int DATA_W = 32,
  parameter int N      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_desc,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [$clog2($clog2(N)*($clog2(N)+1)/2+1)-1:0] busy
);

  localparam int LOG_N  = $clog2(N);
  localparam int L      = LOG_N * (LOG_N + 1) / 2;
  localparam int BUSY_W = $clog2(L + 1);

  // Stage registers
  logic [N*DATA_W-1:0] stage_data [L];
  logic [L-1:0]        stage_valid;
  logic [L-1:0]        stage_desc;

  // Values entering each compare column, and the column results
  logic [N*DATA_W-1:0] net_in [L];
  logic [L-1:0]        net_valid;
  logic [L-1:0]        net_desc;
  wire  [N*DATA_W-1:0] net_out [L];

  logic adv;

  // The whole pipeline moves whenever the last stage is empty or being drained
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stage_valid[L-1];
  assign out_data  = stage_data[L-1];

  // Route the input port into column 0 and each register bank into the next column
  always_comb begin
    net_in[0]    = in_data;
    net_valid[0] = in_valid;
    net_desc[0]  = in_desc;
    for (int s = 1; s < L; s++) begin
      net_in[s]    = stage_data[s-1];
      net_valid[s] = stage_valid[s-1];
      net_desc[s]  = stage_desc[s-1];
    end
  end

  // Bitonic schedule: merge phase p (block size 2^p) has p steps with the
  // compare span halving each step; column index is p*(p-1)/2 + q.
  // Lanes whose block bit is set sort the opposite way so that adjacent
  // blocks form a bitonic sequence; the final merge is one direction only.
  // The vector's desc bit flips every cell's direction.
  for (genvar p = 1; p <= LOG_N; p++) begin : g_merge
    for (genvar q = 0; q < p; q++) begin : g_step
      localparam int S    = p * (p - 1) / 2 + q;
      localparam int SPAN = 1 << (p - 1 - q);
      localparam int BLK  = 1 << p;
      for (genvar i = 0; i < N; i++) begin : g_lane
        if ((i & SPAN) == 0) begin : g_cell
          localparam int   J       = i + SPAN;
          localparam logic BASE_UP = ((i & BLK) == 0);

          logic [DATA_W-1:0] a;
          logic [DATA_W-1:0] b;
          logic              up;
          logic              swap;

          assign a    = net_in[S][i*DATA_W +: DATA_W];
          assign b    = net_in[S][J*DATA_W +: DATA_W];
          assign up   = BASE_UP ^ net_desc[S];
          // Strict compare so equal elements pass straight through
          assign swap = up ? (a > b) : (a < b);

          assign net_out[S][i*DATA_W +: DATA_W] = swap ? b : a;
          assign net_out[S][J*DATA_W +: DATA_W] = swap ? a : b;
        end
      end
    end
  end

  // Register banks: clear on reset, shift one column forward on advance, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < L; s++) begin
        stage_data[s] <= '0;
      end
      stage_valid <= '0;
      stage_desc  <= '0;
    end else if (adv) begin
      for (int s = 0; s < L; s++) begin
        stage_data[s] <= net_out[s];
      end
      stage_valid <= net_valid;
      stage_desc  <= net_desc;
    end
  end

  // Occupancy is the population count of the stage valid bits
  always_comb begin
    busy = '0;
    for (int s = 0; s < L; s++) begin
      busy = busy + BUSY_W'(stage_valid[s]);
    end
  end

endmodule
